// File: rtl/finalproject_trivia_pio_pkg.sv
// Shared constants and types for the trivia answer-button PIO block.
package finalproject_trivia_pio_pkg;

  localparam int unsigned ADDR_W        = 2;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned WARM_W        = 2;

  // Edge detection is held off while the warm-up counter is below this value.
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(3);

  localparam logic [ADDR_W-1:0] ADDR_DATA    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_DIR     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = ADDR_W'(3);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/finalproject_trivia_pio_debounce.sv
// One-bit level debouncer: output follows input only after DEBOUNCE_CYCLES
// consecutive disagreeing cycles; tracks the input directly while track=1.
module finalproject_trivia_pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic track,
  input  logic din,
  output logic q
);

  localparam int unsigned LIMIT = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  // Any agreement restarts the run; the LIMIT-th disagreeing cycle flips q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (track) begin
      q   <= din;
      cnt <= '0;
    end else if (din == q) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(LIMIT - 1)) begin
      q   <= din;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/finalproject_trivia_pio_input_buttons.sv
// Avalon-MM answer-button PIO: synchronizer, rising-edge capture, irq mask.
// Optional per-bit debounce enabled by defining FINALPROJECT_TRIVIA_PIO_DEBOUNCE_EN.
module finalproject_trivia_pio_input_buttons
  import finalproject_trivia_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = DEFAULT_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  bus_req_t          req;
  logic [WIDTH-1:0]  s1;
  logic [WIDTH-1:0]  s2;
  logic [WIDTH-1:0]  cond;
  logic [WIDTH-1:0]  prev;
  logic [WIDTH-1:0]  irqmask;
  logic [WIDTH-1:0]  edgecap;
  logic [WIDTH-1:0]  rise;
  logic [WIDTH-1:0]  clr;
  logic [WARM_W-1:0] warm_cnt;
  logic              warm;
  logic              unused_wdata;

  assign req.wr    = chipselect & ~write_n;
  assign req.addr  = address;
  assign req.wdata = writedata;

  assign unused_wdata = ^writedata;

  // Two-flop synchronizer for the asynchronous button levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // Warm-up counter saturates at WARM_DONE; edges are ignored until then.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt <= '0;
    end else if (warm) begin
      warm_cnt <= warm_cnt + WARM_W'(1);
    end
  end

  assign warm = (warm_cnt != WARM_DONE);

`ifdef FINALPROJECT_TRIVIA_PIO_DEBOUNCE_EN
  logic [WIDTH-1:0] db;

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    finalproject_trivia_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .track   (warm),
      .din     (s2[i]),
      .q       (db[i])
    );
  end

  assign cond = db;
`else
  localparam int unsigned UNUSED_DEBOUNCE_CYCLES = DEBOUNCE_CYCLES;

  assign cond = s2;
`endif

  // prev follows s2 during warm-up so a level held through reset is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else if (warm) begin
      prev <= s2;
    end else begin
      prev <= cond;
    end
  end

  assign rise = cond & ~prev & {WIDTH{~warm}};

  always_comb begin
    clr = '0;
    if (req.wr && (req.addr == ADDR_EDGECAP)) begin
      clr = req.wdata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (req.wr && (req.addr == ADDR_IRQMASK)) begin
      irqmask <= req.wdata[WIDTH-1:0];
    end
  end

  // Set has priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap <= '0;
    end else begin
      edgecap <= (edgecap & ~clr) | rise;
    end
  end

  assign irq = |(edgecap & irqmask);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = DATA_W'(cond);
      ADDR_DIR:     readdata = '0;
      ADDR_IRQMASK: readdata = DATA_W'(irqmask);
      ADDR_EDGECAP: readdata = DATA_W'(edgecap);
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_finalproject_trivia_pio_input_buttons.sv
// Directed self-checking bench for finalproject_trivia_pio_input_buttons.
// Debounce-specific stimulus runs when FINALPROJECT_TRIVIA_PIO_DEBOUNCE_EN is defined.
module tb_finalproject_trivia_pio_input_buttons;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DBC   = 8;
`ifdef FINALPROJECT_TRIVIA_PIO_DEBOUNCE_EN
  localparam int unsigned LAT   = DBC;
`else
  localparam int unsigned LAT   = 0;
`endif
  localparam int unsigned SETTLE = 4 + LAT;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int checks = 0;
  int errors = 0;

  finalproject_trivia_pio_input_buttons #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DBC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check_val(tag, readdata, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'b0010;

    // Reset with button 1 held.
    step(3);
    check_reg("rst_data", 2'd0, 32'h0);
    check_reg("rst_dir", 2'd1, 32'h0);
    check_reg("rst_mask", 2'd2, 32'h0);
    check_reg("rst_edge", 2'd3, 32'h0);
    check_val("rst_irq", 32'(irq), 32'h0);

    @(negedge clk);
    reset_n = 1'b1;
    step(10 + LAT);
    check_reg("held_edge", 2'd3, 32'h0);
    check_val("held_irq", 32'(irq), 32'h0);
    check_reg("held_data", 2'd0, 32'h2);

    // Release: falling edge must not capture.
    in_port = 4'b0000;
    step(SETTLE);
    check_reg("fall_data", 2'd0, 32'h0);
    check_reg("fall_edge", 2'd3, 32'h0);

    // Rising edge latency on button 1.
    bus_write(2'd2, 32'hF);
    in_port[1] = 1'b1;
    step(1);
    check_reg("lat_n_data", 2'd0, 32'h0);
    step(LAT + 1);
    check_reg("lat_n1_data", 2'd0, 32'h2);
    check_reg("lat_n1_edge", 2'd3, 32'h0);
    step(1);
    check_reg("lat_n2_edge", 2'd3, 32'h2);
    check_val("lat_n2_irq", 32'(irq), 32'h1);
    bus_write(2'd3, 32'h2);
    check_reg("clr_edge", 2'd3, 32'h0);
    check_val("clr_irq", 32'(irq), 32'h0);
    step(5);
    check_reg("level_once", 2'd3, 32'h0);

    // Clear and set of bit 0 in the same cycle: set wins.
    in_port[0] = 1'b1;
    step(2 + LAT);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd3;
    writedata  = 32'h1;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    check_reg("set_wins", 2'd3, 32'h1);
    bus_write(2'd3, 32'h1);
    check_reg("clr_bit0", 2'd3, 32'h0);
    in_port = 4'b0000;
    step(SETTLE);

    // Masked capture on button 2.
    bus_write(2'd2, 32'h1);
    in_port = 4'b0100;
    step(SETTLE);
    check_reg("mask_edge", 2'd3, 32'h4);
    check_val("mask_irq0", 32'(irq), 32'h0);
    bus_write(2'd2, 32'h5);
    check_val("mask_irq1", 32'(irq), 32'h1);
    bus_write(2'd3, 32'hF);
    check_val("mask_irq_clr", 32'(irq), 32'h0);
    in_port = 4'b0000;
    step(SETTLE);

    // DIR register reads 0; irqmask truncates to WIDTH.
    bus_write(2'd1, 32'hFFFF_FFFF);
    check_reg("dir_read", 2'd1, 32'h0);
    bus_write(2'd2, 32'hFF);
    check_reg("mask_read", 2'd2, 32'hF);

`ifdef FINALPROJECT_TRIVIA_PIO_DEBOUNCE_EN
    // 5-cycle glitch is filtered; an 8+ cycle hold is accepted.
    in_port[0] = 1'b1;
    step(5);
    in_port[0] = 1'b0;
    step(20);
    check_reg("glitch_data", 2'd0, 32'h0);
    check_reg("glitch_edge", 2'd3, 32'h0);
    in_port[0] = 1'b1;
    step(14);
    check_reg("hold_data", 2'd0, 32'h1);
    check_reg("hold_edge", 2'd3, 32'h1);
    bus_write(2'd3, 32'h1);
    in_port = 4'b0000;
    step(SETTLE);
`endif

    // Asynchronous reset clears everything without a clock edge.
    in_port = 4'b1000;
    step(SETTLE);
    check_reg("pre_rst_edge", 2'd3, 32'h8);
    check_val("pre_rst_irq", 32'(irq), 32'h1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_val("async_irq", 32'(irq), 32'h0);
    check_val("async_edge", readdata, 32'h0);
    step(2);
    @(negedge clk);
    reset_n = 1'b1;
    step(10 + LAT);
    check_reg("rerst_edge", 2'd3, 32'h0);
    check_reg("rerst_mask", 2'd2, 32'h0);
    check_reg("rerst_data", 2'd0, 32'h8);
    check_val("rerst_irq", 32'(irq), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
